// File: rtl/fnd_pkg.sv
// Shared constants for the FND display controller: segment fonts,
// special glyphs, FSM state encoding and elaboration-time helpers.
package fnd_pkg;

  // Active-low 7-segment glyphs, bit order {dp,g,f,e,d,c,b,a}; dp kept off.
  localparam logic [7:0] FONT_0 = 8'hC0;
  localparam logic [7:0] FONT_1 = 8'hF9;
  localparam logic [7:0] FONT_2 = 8'hA4;
  localparam logic [7:0] FONT_3 = 8'hB0;
  localparam logic [7:0] FONT_4 = 8'h99;
  localparam logic [7:0] FONT_5 = 8'h92;
  localparam logic [7:0] FONT_6 = 8'h82;
  localparam logic [7:0] FONT_7 = 8'hF8;
  localparam logic [7:0] FONT_8 = 8'h80;
  localparam logic [7:0] FONT_9 = 8'h90;

  localparam logic [7:0] SEG_DASH  = 8'b10111111;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Conversion FSM encoding.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  // Glyph for one BCD nibble; non-decimal codes show a dash.
  function automatic logic [7:0] seg_font(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = FONT_0;
      4'd1:    seg = FONT_1;
      4'd2:    seg = FONT_2;
      4'd3:    seg = FONT_3;
      4'd4:    seg = FONT_4;
      4'd5:    seg = FONT_5;
      4'd6:    seg = FONT_6;
      4'd7:    seg = FONT_7;
      4'd8:    seg = FONT_8;
      4'd9:    seg = FONT_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Decimal digits needed to hold any bin_w-bit value (log10(2) ~ 0.302),
  // never fewer than the number of displayed digits so the display slice exists.
  function automatic int acc_digits(input int bin_w, input int digits);
    int d;
    d = (bin_w * 302 + 999) / 1000 + 1;
    return (d > digits) ? d : digits;
  endfunction

  // 10^n for the overflow threshold.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: accepts a binary value on a
// valid/ready handshake, converts one bit per cycle, then latches the
// displayable BCD digits and the overflow flag.
module bin_to_bcd_seq
  import fnd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int ACC_D = acc_digits(BIN_W, DIGITS);
  localparam int ACC_W = 4 * ACC_D;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // Comparison width large enough for both the input and 10^DIGITS-1.
  localparam int CMP_W = (BIN_W > 32) ? BIN_W : 32;
  localparam logic [CMP_W-1:0] MAX_SHOWN = CMP_W'(pow10(DIGITS) - 64'd1);

  logic [1:0]       state;
  logic [BIN_W-1:0] shreg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_next;

  // Add-3 correction of every accumulator nibble above 4 before the shift.
  always_comb begin
    // NOTE: default assignment first so no path leaves acc_adj unassigned (no latch).
    acc_adj = acc;
    for (int i = 0; i < ACC_D; i++) begin
      if (acc[4*i +: 4] > 4'd4) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Handshake FSM, shift engine and result/overflow registers.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all of them update together.
    if (reset_p) begin
      // NOTE: every register, including the datapath, is cleared so an aborted
      // conversion leaves nothing behind.
      state    <= IDLE;
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= bin;
            acc      <= '0;
            cnt      <= CNT_W'(BIN_W);
            ovf_next <= (CMP_W'(bin) > MAX_SHOWN);
            state    <= CONV;
          end
        end
        CONV: begin
          acc   <= {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};
          shreg <= {shreg[BIN_W-2:0], 1'b0};
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= LATCH;
        end
        LATCH: begin
          // An out-of-range value keeps the previous digits; ovf drives the dashes.
          if (!ovf_next) bcd <= acc[4*DIGITS-1:0];
          ovf   <= ovf_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == CONV);
  assign done     = (state == LATCH);

endmodule

// File: rtl/fnd_bcd_scan_ctrl.sv
// Multi-digit FND controller: sequential binary-to-BCD conversion plus a
// free-running digit scanner with leading-zero blanking and overflow dashes.
module fnd_bcd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int BIN_W    = 12,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  input  logic                  blank_en,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7:0]            seg_7,
  output logic [DIGITS-1:0]     com
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic [IDX_W-1:0]  idx;
  logic [DIGITS-1:0] upper_zero;
  logic              zero_run;
  logic [3:0]        nib;
  logic [7:0]        seg_next;

  bin_to_bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk      (clk),
    .reset_p  (reset_p),
    .bin      (bin),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .bcd      (bcd)
  );

  assign tick = (pre_cnt == PRE_W'(SCAN_DIV - 1));

  // Dwell prescaler and digit index; runs regardless of conversion activity.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // upper_zero[i]: this digit and every more significant digit are zero.
  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (bcd[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  // Glyph selection for the digit currently addressed by idx.
  always_comb begin
    nib = bcd[4*idx +: 4];
    if (ovf)
      seg_next = SEG_DASH;
    else if (blank_en && (idx != '0) && upper_zero[idx])
      seg_next = SEG_BLANK;
    else
      seg_next = seg_font(nib);
  end

  // Segment and common registers load from the same idx so they switch together.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      seg_7 <= FONT_0;
      com   <= DIGITS'(1);
    end else begin
      seg_7 <= seg_next;
      com   <= DIGITS'(1) << idx;
    end
  end

endmodule

// File: tb/tb_fnd_bcd_scan_ctrl.sv
// Bench for fnd_bcd_scan_ctrl: a 4-digit and a 3-digit instance, directed
// vectors, per-instance scoreboards checked when done is seen.
module tb_fnd_bcd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst4, rst3, valid4, valid3, blank4, blank3;
  logic [11:0] bin4, bin3;
  logic        rdy4, busy4, done4, ovf4;
  logic        rdy3, busy3, done3, ovf3;
  logic [15:0] bcd4;
  logic [11:0] bcd3;
  logic [7:0]  seg4, seg3;
  logic [3:0]  com4;
  logic [2:0]  com3;

  int checks = 0;
  int errors = 0;

  logic [16:0] q4[$];
  logic [16:0] q3[$];

  always #5 clk = ~clk;

  fnd_bcd_scan_ctrl #(.BIN_W(12), .DIGITS(4), .SCAN_DIV(4)) dut4 (
    .clk(clk), .reset_p(rst4), .bin(bin4), .in_valid(valid4), .in_ready(rdy4),
    .busy(busy4), .done(done4), .ovf(ovf4), .blank_en(blank4), .bcd(bcd4),
    .seg_7(seg4), .com(com4)
  );

  fnd_bcd_scan_ctrl #(.BIN_W(12), .DIGITS(3), .SCAN_DIV(4)) dut3 (
    .clk(clk), .reset_p(rst3), .bin(bin3), .in_valid(valid3), .in_ready(rdy3),
    .busy(busy3), .done(done3), .ovf(ovf3), .blank_en(blank3), .bcd(bcd3),
    .seg_7(seg3), .com(com3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int u);  return (u == 4) ? rdy4 : rdy3;   endfunction
  function automatic logic dn(input int u);   return (u == 4) ? done4 : done3; endfunction
  function automatic logic bz(input int u);   return (u == 4) ? busy4 : busy3; endfunction
  function automatic logic [7:0] cur_com(input int u);
    return (u == 4) ? 8'(com4) : 8'(com3);
  endfunction
  function automatic logic [7:0] cur_seg(input int u);
    return (u == 4) ? seg4 : seg3;
  endfunction

  // Scoreboard monitors: on done, pop the expected result and compare it
  // once the display register has loaded on the next edge.
  initial begin : mon4
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        check("sb4_pending", 32'(q4.size() != 0), 1);
        if (q4.size() != 0) begin
          e = q4.pop_front();
          step();
          check("sb4_bcd", 32'(bcd4), 32'(e[15:0]));
          check("sb4_ovf", 32'(ovf4), 32'(e[16]));
        end
      end
    end
  end

  initial begin : mon3
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (done3 === 1'b1) begin
        check("sb3_pending", 32'(q3.size() != 0), 1);
        if (q3.size() != 0) begin
          e = q3.pop_front();
          step();
          check("sb3_bcd", 32'(bcd3), 32'(e[11:0]));
          check("sb3_ovf", 32'(ovf3), 32'(e[16]));
        end
      end
    end
  end

  // One conversion with handshake timing checks; expected result goes to the scoreboard.
  task automatic send(input int u, input logic [11:0] v, input logic [16:0] exp_e);
    int n;
    int nb;
    n = 0;
    while (!rdy(u) && n < 40) begin step(); n++; end
    check("ready_before_send", 32'(rdy(u)), 1);
    if (u == 4) begin q4.push_back(exp_e); bin4 = v; valid4 = 1'b1; end
    else        begin q3.push_back(exp_e); bin3 = v; valid3 = 1'b1; end
    step();
    valid4 = 1'b0;
    valid3 = 1'b0;
    n  = 0;
    nb = 0;
    while (!dn(u) && n < 40) begin
      if (bz(u)) nb++;
      step();
      n++;
    end
    // done is visible BIN_W edges after the accept edge (13th cycle incl. accept).
    check("done_latency", n, 12);
    check("busy_cycles", nb, 12);
    check("ready_in_latch", 32'(rdy(u)), 0);
    step();
    check("ready_after_done", 32'(rdy(u)), 1);
    check("busy_after_done", 32'(bz(u)), 0);
  endtask

  // Visit every digit position and compare its glyph; exp holds digit d at [8*d +: 8].
  task automatic check_scan(input int u, input logic [31:0] exp);
    int n;
    step();
    for (int d = 0; d < u; d++) begin
      n = 0;
      while (cur_com(u) != (8'd1 << d) && n < 40) begin step(); n++; end
      check($sformatf("com_u%0d_d%0d", u, d), 32'(cur_com(u)), 32'(8'd1 << d));
      check($sformatf("seg_u%0d_d%0d", u, d), 32'(cur_seg(u)), 32'(exp[8*d +: 8]));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic [3:0] prev;
    logic seen;

    rst4 = 1'b1; rst3 = 1'b1; valid4 = 1'b0; valid3 = 1'b0;
    blank4 = 1'b0; blank3 = 1'b0; bin4 = '0; bin3 = '0;
    step();
    step();
    rst4 = 1'b0;
    rst3 = 1'b0;

    // Reset state
    check("rst_ready", 32'(rdy4), 1);
    check("rst_busy",  32'(busy4), 0);
    check("rst_done",  32'(done4), 0);
    check("rst_ovf",   32'(ovf4), 0);
    check("rst_bcd",   32'(bcd4), 32'h0000);
    check("rst_com",   32'(com4), 32'b0001);
    check("rst_seg",   32'(seg4), 32'hC0);

    // Scan rotation: one step every 4 cycles, wrapping 1000 -> 0001
    for (int s = 0; s < 5; s++) begin
      prev = com4;
      n = 0;
      while (com4 == prev && n < 20) begin step(); n++; end
      if (s > 0) check("scan_period", n, 4);
      check("scan_rotate", 32'(com4), 32'({prev[2:0], prev[3]}));
    end

    // Basic conversion and its display
    send(4, 12'd1234, {1'b0, 16'h1234});
    check_scan(4, 32'hF9A4B099);

    // Requests while busy are dropped
    q4.push_back({1'b0, 16'h4095});
    bin4 = 12'd4095; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    step();
    bin4 = 12'd1; valid4 = 1'b1;
    repeat (5) step();
    valid4 = 1'b0;
    n = 0;
    while (!done4 && n < 40) begin step(); n++; end
    check("ignore_done_latency", n, 6);
    step();
    seen = 1'b0;
    repeat (30) begin step(); if (busy4 || done4) seen = 1'b1; end
    check("no_second_conv", 32'(seen), 0);
    check_scan(4, 32'h99C09092);

    // Reset during a conversion
    bin4 = 12'd2048; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    repeat (4) step();
    check("busy_before_reset", 32'(busy4), 1);
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    check("midrst_bcd",   32'(bcd4), 32'h0000);
    check("midrst_busy",  32'(busy4), 0);
    check("midrst_ready", 32'(rdy4), 1);
    seen = 1'b0;
    repeat (20) begin step(); if (done4) seen = 1'b1; end
    check("midrst_no_done", 32'(seen), 0);

    // Leading-zero blanking
    blank4 = 1'b1;
    send(4, 12'd7, {1'b0, 16'h0007});
    check_scan(4, 32'hFFFFFFF8);
    send(4, 12'd0, {1'b0, 16'h0000});
    check_scan(4, 32'hFFFFFFC0);
    blank4 = 1'b0;
    check_scan(4, 32'hC0C0C0C0);

    // Overflow on the 3-digit instance
    send(3, 12'd123, {1'b0, 16'h0123});
    check_scan(3, 32'h00F9A4B0);
    send(3, 12'd1000, {1'b1, 16'h0123});
    check_scan(3, 32'h00BFBFBF);
    send(3, 12'd999, {1'b0, 16'h0999});
    check_scan(3, 32'h00909090);

    repeat (4) step();
    check("sb4_drained", q4.size(), 0);
    check("sb3_drained", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_bcd_scan_ctrl.md
Name: fnd_bcd_scan_ctrl

Overview:
Parametrised multi-digit 7-segment (FND) display controller. It accepts a binary value through a valid/ready handshake and converts it to BCD sequentially, using double-dabble with one bit per cycle. It then time-multiplexes the digits onto a shared seg_7 bus with a one-hot com select. The block sits between counter/sensor logic in the RC car top level and the FND pins, and replaces fixed single-digit display wiring.

Parameters:
BIN_W, 12, width of binary input (>=4)
DIGITS, 4, number of FND digits driven (1..8)
SCAN_DIV, 100000, clk cycles per digit dwell (>=2; 1 ms at 100 MHz)

Ports:
clk  in  1  system clock, all logic on posedge
reset_p  in  1  synchronous active-high reset
bin  in  BIN_W  binary value to display
in_valid  in  1  request to convert and display bin
in_ready  out  1  high when idle; a transfer occurs when in_valid && in_ready
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when a new value is latched for display
ovf  out  1  last accepted value >= 10^DIGITS
blank_en  in  1  1 = blank leading zeros
bcd  out  4*DIGITS  currently displayed BCD; digit 0 = bcd[3:0] = least significant
seg_7  out  8  segment drive, active-low, {dp,g,f,e,d,c,b,a}; dp always 1 (off)
com  out  DIGITS  digit select, one-hot, active-high, com[0] = least significant digit

Behaviour:
- Clock and reset: single clock, clk. Reset reset_p is synchronous and active-high. All state is cleared on the reset_p=1 clock edge.
- Reset values: in_ready=1, busy=0, done=0, ovf=0, bcd=0, com={{DIGITS-1}{0},1}, seg_7=8'b11000000 ("0"). Scan prescaler=0, digit index=0.
- Reset mid-conversion: the conversion is aborted, no done pulse is issued, and the display is cleared to 0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid, capture bin into the shift register, clear the BCD accumulator, set the iteration count to BIN_W, and go to CONV.
  - ovf_next = (bin > 10^DIGITS-1), computed at capture.
- FSM CONV:
  - busy=1, in_ready=0.
  - Each cycle: every BCD nibble >4 gets +3, then {bcd_acc, shreg} shifts left by 1.
  - Exactly BIN_W cycles, then go to LATCH.
- FSM LATCH (1 cycle):
  - If ovf_next=0: bcd <= bcd_acc[4*DIGITS-1:0]. If ovf_next=1: bcd is left unchanged.
  - ovf <= ovf_next; done=1; next state IDLE.
- Handshake:
  - Latency from the accept edge to the done pulse is BIN_W+1 cycles. in_ready returns high in the cycle after done.
  - in_valid while busy is ignored; there is no queueing.
  - A new in_valid in the same cycle as done is accepted on the following (IDLE) cycle.
- Accumulator width: the internal BCD accumulator is wide enough for the full BIN_W input (ceil(BIN_W*0.302)+1 digits). ovf is detected by comparison, never by truncation.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and ticks at wrap.
  - On tick, the digit index advances and wraps DIGITS-1 -> 0.
  - com = 1 << index.
  - Scanning runs continuously, independent of the FSM. A conversion never stalls or resets the scan.
- seg_7 output:
  - Registered. It reflects the current index and bcd one cycle after the index changes.
  - com and seg_7 change on the same edge; the index is pipelined so they stay aligned.
- Fonts (active-low):
  - 0-9 as 7-seg font: C0,F9,A4,B0,99,92,82,F8,80,90.
  - Nibbles A-F never occur in bcd; if one does, show dash 8'b10111111.
- ovf display: while ovf=1, every digit shows dash 8'b10111111.
- Leading-zero blanking:
  - Applies when blank_en=1, index>0, and all nibbles at index and above are 0: seg_7=8'hFF.
  - Digit 0 is never blanked, so value 0 shows "0".
  - blank_en is sampled combinationally each cycle.

Decomposition:
- Shared package fnd_pkg holds:
  - the font constants FONT_0..FONT_9;
  - SEG_DASH=8'b10111111 and SEG_BLANK=8'hFF;
  - FSM state encoding IDLE/CONV/LATCH.
- Natural sub-module: bin_to_bcd_seq, containing the sequential double-dabble engine with the handshake, FSM and ovf logic.
- The top contains the prescaler, digit mux, blanking and font lookup.

Test Plan:
- Configuration: BIN_W=12, DIGITS=4, SCAN_DIV=4 unless stated otherwise.
- Reset: assert reset_p 2 cycles -> in_ready=1, busy=0, bcd=16'h0000, com=4'b0001, seg_7=8'hC0. com advances 0001->0010->0100->1000->0001, one step every 4 cycles.
- Conversion: bin=12'd1234, in_valid 1 cycle -> busy high 12 cycles, done pulse 13 cycles after accept, bcd=16'h1234, ovf=0. Scan shows com=0001:8'h99, 0010:8'hB0, 0100:8'hA4, 1000:8'hF9.
- Ignore while busy: bin=12'd4095 accepted, then in_valid with bin=12'd1 for cycles 2-6 -> exactly one done pulse, bcd=16'h4095, and no second conversion without a fresh in_valid in IDLE.
- Blanking: blank_en=1, bin=12'd7 -> digit0=8'hF8, digits1-3=8'hFF. Then bin=0 -> digit0=8'hC0, digits1-3=8'hFF. With blank_en=0 and bin=0, all digits show 8'hC0.
- Overflow: DIGITS=3, bin=12'd1000 -> ovf=1, all three digits 8'hBF, bcd keeps its previous value. Then bin=12'd999 -> ovf=0, bcd=12'h999.
- Reset mid-conversion: reset_p at cycle 5 after accepting bin=12'd2048 -> no done pulse, bcd=0, busy=0, in_ready=1 on the next cycle.
